// File: rtl/stack_calc_if.sv
// Command/status bundle for stack_calc: valid/ready command channel plus registered stack status.
interface stack_calc_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             zero;
  logic             err;
  logic             done;

  modport master (
    output cmd_valid, cmd, alu_op, din,
    input  cmd_ready, top, depth, zero, err, done
  );

  modport slave (
    input  cmd_valid, cmd, alu_op, din,
    output cmd_ready, top, depth, zero, err, done
  );
endinterface

// File: rtl/stack_calc.sv
// RPN calculator: DEPTH-entry operand stack with PUSH/POP/OP/CLEAR commands and a sticky error.
module stack_calc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  stack_calc_if.slave bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [1:0] CmdPush  = 2'b00;
  localparam logic [1:0] CmdPop   = 2'b01;
  localparam logic [1:0] CmdOp    = 2'b10;
  localparam logic [1:0] CmdClear = 2'b11;

  // riscv_alu_constants encodings
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluLt  = 4'b0111;
  localparam logic [3:0] AluSrl = 4'b1000;
  localparam logic [3:0] AluSll = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;
  localparam logic [3:0] AluXor = 4'b1101;

  typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] top_q, op1_q, op2_q, res_q, alu_res, nos_val;
  logic [3:0]       aluop_q;
  logic [DW-1:0]    depth_q;
  logic             zero_q, err_q, done_q;
  logic             accept, full, empty, op_ok, op_start;
  logic [AW-1:0]    push_idx, nos_idx;
  logic [SW-1:0]    shamt;

  always_comb begin
    accept   = bus.cmd_valid && (state_q == StIdle);
    full     = (depth_q == DW'(DEPTH));
    empty    = (depth_q == '0);
    push_idx = AW'(depth_q);
    nos_idx  = AW'(depth_q - DW'(2));
    nos_val  = stk_q[nos_idx];
    case (bus.alu_op)
      AluAnd, AluOr, AluAdd, AluSub, AluLt, AluSrl, AluSll, AluSra, AluXor: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
    op_start = accept && (bus.cmd == CmdOp) && op_ok && (depth_q >= DW'(2));
  end

  always_comb begin
    shamt = op2_q[SW-1:0];
    case (aluop_q)
      AluAnd:  alu_res = op1_q & op2_q;
      AluOr:   alu_res = op1_q | op2_q;
      AluXor:  alu_res = op1_q ^ op2_q;
      AluAdd:  alu_res = op1_q + op2_q;
      AluSub:  alu_res = op1_q - op2_q;
      AluLt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(op1_q) < $signed(op2_q)};
      AluSll:  alu_res = op1_q << shamt;
      AluSrl:  alu_res = op1_q >> shamt;
      AluSra:  alu_res = $unsigned($signed(op1_q) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (op_start) state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      depth_q <= '0;
      top_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      aluop_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            // A valid OP reports done only after its WRITE cycle
            done_q <= !op_start;
            unique case (bus.cmd)
              CmdPush: begin
                if (!full) begin
                  depth_q <= depth_q + DW'(1);
                  top_q   <= bus.din;
                  zero_q  <= (bus.din == '0);
                end else begin
                  err_q <= 1'b1;
                end
              end
              CmdPop: begin
                if (!empty) begin
                  depth_q <= depth_q - DW'(1);
                  top_q   <= (depth_q >= DW'(2)) ? nos_val : '0;
                  zero_q  <= (depth_q >= DW'(2)) && (nos_val == '0);
                end else begin
                  err_q <= 1'b1;
                end
              end
              CmdOp: begin
                if (op_start) begin
                  op1_q   <= nos_val;
                  op2_q   <= top_q;
                  aluop_q <= bus.alu_op;
                end else begin
                  err_q <= 1'b1;
                end
              end
              CmdClear: begin
                depth_q <= '0;
                top_q   <= '0;
                zero_q  <= 1'b0;
                err_q   <= 1'b0;
              end
            endcase
          end
        end
        StExec: res_q <= alu_res;
        StWrite: begin
          depth_q <= depth_q - DW'(1);
          top_q   <= res_q;
          zero_q  <= (res_q == '0);
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries above depth are never observed
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept && (bus.cmd == CmdPush) && !full) begin
        stk_q[push_idx] <= bus.din;
      end else if (state_q == StWrite) begin
        stk_q[nos_idx] <= res_q;
      end
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.top       = top_q;
  assign bus.depth     = depth_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_stack_calc.sv
// Randomised scoreboard bench for stack_calc against a queue-based RPN reference model.
module tb_stack_calc;
  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  localparam logic [1:0] C_PUSH = 2'b00, C_POP = 2'b01, C_OP = 2'b10, C_CLR = 2'b11;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_LT = 4'b0111, OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001, OP_SRA = 4'b1010, OP_XOR = 4'b1101;

  typedef struct {
    logic [W-1:0] top;
    int           depth;
    logic         zero;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0] mstk[$];
  logic         merr = 1'b0;
  exp_t         sbq[$];

  stack_calc_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit supported(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LT, OP_SRL, OP_SLL, OP_SRA, OP_XOR};
  endfunction

  function automatic logic [W-1:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] op);
    int sh;
    sh = int'(b) % W;
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_LT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      OP_SLL: return a << sh;
      OP_SRL: return a >> sh;
      OP_SRA: return $unsigned($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] c, input logic [3:0] op, input logic [W-1:0] d,
                             output int lat);
    logic [W-1:0] a, b;
    lat = 1;
    case (c)
      C_PUSH: if (mstk.size() < D) mstk.push_back(d); else merr = 1'b1;
      C_POP:  if (mstk.size() > 0) void'(mstk.pop_back()); else merr = 1'b1;
      C_CLR:  begin mstk.delete(); merr = 1'b0; end
      default: begin
        if (mstk.size() < 2 || !supported(op)) begin
          merr = 1'b1;
        end else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          mstk.push_back(model_alu(a, b, op));
          lat = 3;
        end
      end
    endcase
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] op, input logic [W-1:0] d,
                      input bit track);
    int   lat;
    int   n;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.alu_op    = op;
    bus.din       = d;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: cmd_ready 0 for %0d cycles, expected 1", n);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      model_apply(c, op, d, lat);
      e.top   = (mstk.size() > 0) ? mstk[$] : '0;
      e.depth = mstk.size();
      e.zero  = (mstk.size() > 0) && (e.top == '0);
      e.err   = merr;
      e.cyc   = cyc + lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d); send(C_PUSH, 4'h0, d, 1'b1); endtask
  task automatic pop();                       send(C_POP, 4'h0, '0, 1'b1); endtask
  task automatic clr();                       send(C_CLR, 4'h0, '0, 1'b1); endtask
  task automatic alu(input logic [3:0] op);   send(C_OP, op, '0, 1'b1); endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses pending, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: done=1 with no command outstanding (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("top", 32'(bus.top), 32'(e.top));
        check("depth", 32'(bus.depth), e.depth);
        check("zero", 32'(bus.zero), 32'(e.zero));
        check("err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c;
    logic [3:0] op;
    logic [W-1:0] d;
    int r;

    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.alu_op    = '0;
    bus.din       = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_top", 32'(bus.top), 0);
    check("rst_depth", 32'(bus.depth), 0);
    check("rst_zero", 32'(bus.zero), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    push(16'd5); push(16'd3); alu(OP_ADD); drain();
    check("add_top", 32'(bus.top), 8);
    check("add_depth", 32'(bus.depth), 1);
    check("add_err", 32'(bus.err), 0);

    clr(); push(16'd2); push(16'd7); alu(OP_SUB); drain();
    check("sub_top", 32'(bus.top), 32'hFFFB);
    push(16'hFFFB); alu(OP_LT); drain();
    check("lt_top", 32'(bus.top), 0);
    check("lt_zero", 32'(bus.zero), 1);

    clr();
    for (int i = 0; i < D; i++) push(16'd1);
    push(16'd9); drain();
    check("full_err", 32'(bus.err), 1);
    check("full_depth", 32'(bus.depth), D);
    check("full_top", 32'(bus.top), 1);
    clr(); drain();
    check("clr_err", 32'(bus.err), 0);
    check("clr_depth", 32'(bus.depth), 0);

    pop(); drain();
    check("pop_empty_err", 32'(bus.err), 1);
    clr(); push(16'd4); alu(OP_ADD); drain();
    check("op_short_err", 32'(bus.err), 1);
    check("op_short_top", 32'(bus.top), 4);

    clr(); push(16'h8000); push(16'd4); alu(OP_SRA); drain();
    check("sra_top", 32'(bus.top), 32'hF800);
    clr(); push(16'h8000); push(16'd4); alu(OP_SRL); drain();
    check("srl_top", 32'(bus.top), 32'h0800);
    clr(); push(16'h0001); push(16'h0013); alu(OP_SLL); drain();
    check("sll_top", 32'(bus.top), 32'h0008);

    // PUSH issued right after the OP is held through the busy cycles
    clr(); push(16'd10); push(16'd20); alu(OP_ADD); push(16'd7); drain();
    check("held_depth", 32'(bus.depth), 2);
    check("held_top", 32'(bus.top), 7);

    // Reset during EXEC aborts the OP with no done pulse
    clr(); pop(); push(16'd1); push(16'd2); drain();
    send(C_OP, OP_ADD, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_top", 32'(bus.top), 0);
    check("abort_depth", 32'(bus.depth), 0);
    check("abort_err", 32'(bus.err), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    mstk.delete();
    merr = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 40) ? C_PUSH : (r < 60) ? C_POP : (r < 95) ? C_OP : C_CLR;
      case ($urandom_range(0, 9))
        0: op = 4'($urandom_range(0, 15));
        1: op = OP_AND; 2: op = OP_OR; 3: op = OP_ADD; 4: op = OP_SUB;
        5: op = OP_LT; 6: op = OP_SRL; 7: op = OP_SLL; 8: op = OP_SRA;
        default: op = OP_XOR;
      endcase
      d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(c, op, d, 1'b1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
